// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic.
//   - stall_state_e : encoding of the stall sequencer FSM
//   - pipe_ctrl_t   : bundle of pipeline-register enables and NOP loads
//   - REG_ZERO      : architectural $zero register number
//   - NOP_INSTR     : instruction word loaded by a flush or bubble
package mips_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMdBusy  = 2'd1,
        StMemWait = 2'd2
    } stall_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
        logic memwb_bubble;
    } pipe_ctrl_t;

    // Everything advances, nothing squashed.
    localparam pipe_ctrl_t CTRL_RUN        = 8'b1111_0000;
    // Reset value: nothing loads, nothing squashed.
    localparam pipe_ctrl_t CTRL_OFF        = 8'b0000_0000;
    // Multiply/divide occupies EX: hold front end, feed EX/MEM with NOPs.
    localparam pipe_ctrl_t CTRL_MD_FREEZE  = 8'b0001_0010;
    // Data memory stall: hold everything up to EX/MEM, feed MEM/WB with NOPs.
    localparam pipe_ctrl_t CTRL_MEM_FREEZE = 8'b0000_0001;
    // Load-use interlock: hold PC and IF/ID, insert a bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE   = 8'b0011_0100;
    // Taken branch: redirect PC, squash the two younger instructions.
    localparam pipe_ctrl_t CTRL_BRANCH     = 8'b1111_1100;
    // Jump: redirect PC, squash the instruction behind the jump.
    localparam pipe_ctrl_t CTRL_JUMP       = 8'b1111_1000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator.
//   i_ex_memread  : instruction in EX is a load
//   i_ex_rt       : destination register of that load
//   i_id_rs/rt    : source registers of the instruction in ID
//   i_id_uses_rt  : ID instruction actually reads rt
//   o_load_use    : ID needs the load result before it can be forwarded
module hazard_detect
    import mips_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_ex_rt == i_id_rs);
    assign w_rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);

    // A load into $zero produces nothing to wait for.
    assign o_load_use = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard and stall sequencer for the 5-stage MIPS pipeline.
// Owns every pipeline-register enable and NOP load.
//   i_clk, i_rst            : clock (rising edge), asynchronous active-high reset
//   i_id_*                  : register usage / jump of the instruction in ID
//   i_ex_*                  : load, taken branch and multiply/divide status of EX
//   i_mem_req, i_mem_ready  : data memory handshake of the MEM stage
//   o_*_write               : pipeline-register load enables
//   o_ifid_flush, o_*_bubble: load a NOP into that register
//   o_md_done               : multiply/divide result valid this cycle
//   o_mem_err               : one-cycle pulse when a memory wait times out
//   o_stall_count           : saturating count of cycles with the PC frozen
module pipeline_stall_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY  = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_jump,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_branch_taken,
    input  logic             i_ex_md_start,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_idex_write,
    output logic             o_exmem_write,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_exmem_bubble,
    output logic             o_memwb_bubble,
    output logic             o_md_done,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_count
);

    // A single-cycle multiply/divide never stalls.
    localparam bit         MdStalls = (MD_LATENCY > 1);
    localparam logic [7:0] MdInit   = MdStalls ? 8'(MD_LATENCY - 2) : 8'd0;
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    stall_state_e     r_state;
    stall_state_e     w_state_d;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_md_cnt_d;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_d;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_load_use;
    logic             w_memstall;
    logic             w_wait_last;
    pipe_ctrl_t       w_ctrl;
    logic             w_md_done;
    logic             w_mem_err;

    hazard_detect u_hazard_detect (
        .i_ex_memread (i_ex_memread),
        .i_ex_rt      (i_ex_rt),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .o_load_use   (w_load_use)
    );

    assign w_memstall  = i_mem_req && !i_mem_ready;
    assign w_wait_last = (r_wait_cnt == WaitLast);

    // State and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StRun;
            r_md_cnt   <= 8'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_md_cnt   <= w_md_cnt_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d    = r_state;
        w_md_cnt_d   = r_md_cnt;
        w_wait_cnt_d = r_wait_cnt;
        unique case (r_state)
            StRun: begin
                if (w_memstall) begin
                    w_wait_cnt_d = 8'd1;
                    w_state_d    = StMemWait;
                end else if (i_ex_md_start && MdStalls) begin
                    w_md_cnt_d = MdInit;
                    w_state_d  = StMdBusy;
                end
            end
            StMdBusy: begin
                if (r_md_cnt != 8'd0) begin
                    w_md_cnt_d = r_md_cnt - 8'd1;
                end else begin
                    w_state_d = StRun;
                end
            end
            StMemWait: begin
                if (i_mem_ready || w_wait_last) begin
                    w_wait_cnt_d = 8'd0;
                    w_state_d    = StRun;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        w_ctrl    = CTRL_RUN;
        w_md_done = 1'b0;
        w_mem_err = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_memstall) begin
                    w_ctrl = CTRL_MEM_FREEZE;
                end else if (i_ex_md_start) begin
                    if (MdStalls) begin
                        w_ctrl = CTRL_MD_FREEZE;
                    end else begin
                        w_md_done = 1'b1;
                    end
                end else if (i_ex_branch_taken) begin
                    w_ctrl = CTRL_BRANCH;
                end else if (i_id_jump) begin
                    w_ctrl = CTRL_JUMP;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_LOAD_USE;
                end
            end
            StMdBusy: begin
                // Branch/jump/load-use stay frozen in ID/EX and are seen again in RUN;
                // MEM only holds bubbles here, so mem_req is ignored.
                if (r_md_cnt != 8'd0) begin
                    w_ctrl = CTRL_MD_FREEZE;
                end else begin
                    w_md_done = 1'b1;
                end
            end
            StMemWait: begin
                if (i_mem_ready) begin
                    w_ctrl = CTRL_RUN;
                end else if (w_wait_last) begin
                    w_mem_err = 1'b1;
                end else begin
                    w_ctrl = CTRL_MEM_FREEZE;
                end
            end
            default: begin
                w_ctrl = CTRL_RUN;
            end
        endcase
        // Reset overrides everything combinationally, so a stall is dropped at once.
        if (i_rst) begin
            w_ctrl    = CTRL_OFF;
            w_md_done = 1'b0;
            w_mem_err = 1'b0;
        end
    end

    // Performance counter of PC-frozen cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_count <= '0;
        end else if (!w_ctrl.pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign o_pc_write     = w_ctrl.pc_write;
    assign o_ifid_write   = w_ctrl.ifid_write;
    assign o_idex_write   = w_ctrl.idex_write;
    assign o_exmem_write  = w_ctrl.exmem_write;
    assign o_ifid_flush   = w_ctrl.ifid_flush;
    assign o_idex_bubble  = w_ctrl.idex_bubble;
    assign o_exmem_bubble = w_ctrl.exmem_bubble;
    assign o_memwb_bubble = w_ctrl.memwb_bubble;
    assign o_md_done      = w_md_done;
    assign o_mem_err      = w_mem_err;
    assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences, and a second small instance for saturation.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       mem_req;
        logic       mem_ready;
        logic       md_start;
        logic       br;
        logic       jump;
        logic       memread;
        logic       uses_rt;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
    } in_t;

    typedef struct {
        in_t        in;
        logic [7:0] exp;
        logic       done;
    } vec_t;

    // {pc, ifid, idex, exmem, ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}
    localparam logic [7:0] E_RUN = 8'b1111_0000;
    localparam logic [7:0] E_RST = 8'b0000_0000;
    localparam logic [7:0] E_LU  = 8'b0011_0100;
    localparam logic [7:0] E_BR  = 8'b1111_1100;
    localparam logic [7:0] E_JMP = 8'b1111_1000;
    localparam logic [7:0] E_MD  = 8'b0001_0010;
    localparam logic [7:0] E_MEM = 8'b0000_0001;

    in_t         in_s;
    logic [7:0]  got;
    logic        md_done, mem_err;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;
    int exp_stall = 0;
    vec_t vecs[12];

    pipeline_stall_ctrl #(
        .MD_LATENCY  (4),
        .MEM_TIMEOUT (16),
        .CNT_W       (16)
    ) u_dut (
        .i_clk             (clk),
        .i_rst             (in_s.rst),
        .i_id_rs           (in_s.id_rs),
        .i_id_rt           (in_s.id_rt),
        .i_id_uses_rt      (in_s.uses_rt),
        .i_id_jump         (in_s.jump),
        .i_ex_memread      (in_s.memread),
        .i_ex_rt           (in_s.ex_rt),
        .i_ex_branch_taken (in_s.br),
        .i_ex_md_start     (in_s.md_start),
        .i_mem_req         (in_s.mem_req),
        .i_mem_ready       (in_s.mem_ready),
        .o_pc_write        (got[7]),
        .o_ifid_write      (got[6]),
        .o_idex_write      (got[5]),
        .o_exmem_write     (got[4]),
        .o_ifid_flush      (got[3]),
        .o_idex_bubble     (got[2]),
        .o_exmem_bubble    (got[1]),
        .o_memwb_bubble    (got[0]),
        .o_md_done         (md_done),
        .o_mem_err         (mem_err),
        .o_stall_count     (stall_count)
    );

    // Small instance: single-cycle multiply, 2-cycle timeout, 4-bit counter.
    logic       s_rst = 1'b1;
    logic       s_md = 1'b0;
    logic       s_mem_req = 1'b0;
    logic [7:0] s_got;
    logic       s_done, s_err;
    logic [3:0] s_count;

    pipeline_stall_ctrl #(
        .MD_LATENCY  (1),
        .MEM_TIMEOUT (2),
        .CNT_W       (4)
    ) u_sat (
        .i_clk             (clk),
        .i_rst             (s_rst),
        .i_id_rs           (5'd0),
        .i_id_rt           (5'd0),
        .i_id_uses_rt      (1'b0),
        .i_id_jump         (1'b0),
        .i_ex_memread      (1'b0),
        .i_ex_rt           (5'd0),
        .i_ex_branch_taken (1'b0),
        .i_ex_md_start     (s_md),
        .i_mem_req         (s_mem_req),
        .i_mem_ready       (1'b0),
        .o_pc_write        (s_got[7]),
        .o_ifid_write      (s_got[6]),
        .o_idex_write      (s_got[5]),
        .o_exmem_write     (s_got[4]),
        .o_ifid_flush      (s_got[3]),
        .o_idex_bubble     (s_got[2]),
        .o_exmem_bubble    (s_got[1]),
        .o_memwb_bubble    (s_got[0]),
        .o_md_done         (s_done),
        .o_mem_err         (s_err),
        .o_stall_count     (s_count)
    );

    function automatic in_t mk(input logic mreq, input logic mrdy, input logic md,
                               input logic br, input logic jmp, input logic mrd,
                               input logic urt, input logic [4:0] ert,
                               input logic [4:0] irs, input logic [4:0] irt);
        in_t v;
        v.rst = 1'b0;  v.mem_req = mreq; v.mem_ready = mrdy; v.md_start = md;
        v.br = br;     v.jump = jmp;     v.memread = mrd;    v.uses_rt = urt;
        v.ex_rt = ert; v.id_rs = irs;    v.id_rt = irt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and check the outputs.
    task automatic step(input in_t i, input logic [7:0] e, input logic ed, input logic ee,
                        input string nm);
        @(negedge clk);
        in_s = i;
        #2;
        if (i.rst) exp_stall = 0;
        chk({nm, ".ctrl"}, {8'd0, got}, {8'd0, e});
        chk({nm, ".md_done"}, {15'd0, md_done}, {15'd0, ed});
        chk({nm, ".mem_err"}, {15'd0, mem_err}, {15'd0, ee});
        chk({nm, ".stall_count"}, stall_count, exp_stall[15:0]);
        if (!i.rst && !e[7]) exp_stall++;
    endtask

    in_t idle;
    in_t rst_v;

    initial begin
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        rst_v = idle;
        rst_v.rst = 1'b1;
        in_s = rst_v;

        //             mreq mrdy md br jmp mrd urt ex_rt  id_rs  id_rt
        vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_RUN, 1'b0};
        vecs[1]  = '{mk(0, 0, 0, 0, 0, 1, 0, 5'd8, 5'd8, 5'd1), E_LU,  1'b0};
        vecs[2]  = '{mk(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0), E_RUN, 1'b0};
        vecs[3]  = '{mk(0, 0, 0, 0, 0, 1, 1, 5'd9, 5'd3, 5'd9), E_LU,  1'b0};
        vecs[4]  = '{mk(0, 0, 0, 0, 0, 1, 0, 5'd9, 5'd3, 5'd9), E_RUN, 1'b0};
        vecs[5]  = '{mk(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7), E_RUN, 1'b0};
        vecs[6]  = '{mk(0, 0, 0, 1, 0, 1, 0, 5'd8, 5'd8, 5'd0), E_BR,  1'b0};
        vecs[7]  = '{mk(0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0), E_JMP, 1'b0};
        vecs[8]  = '{mk(0, 0, 0, 0, 1, 1, 0, 5'd4, 5'd4, 5'd0), E_JMP, 1'b0};
        vecs[9]  = '{mk(0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0), E_BR,  1'b0};
        vecs[10] = '{mk(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_RUN, 1'b0};
        vecs[11] = '{mk(0, 1, 0, 0, 0, 1, 1, 5'd5, 5'd6, 5'd2), E_RUN, 1'b0};

        step(rst_v, E_RST, 0, 0, "reset");
        step(idle, E_RUN, 0, 0, "after_reset");

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].in, vecs[i].exp, vecs[i].done, 1'b0, $sformatf("vec%0d", i));
        end

        // Multiply: three frozen cycles, RUN-state events and mem_req ignored meanwhile.
        step(mk(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MD, 0, 0, "md_enter");
        step(mk(0, 0, 1, 1, 1, 1, 0, 5'd3, 5'd3, 5'd0), E_MD, 0, 0, "md_busy1");
        step(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MD, 0, 0, "md_busy2");
        step(idle, E_RUN, 1, 0, "md_done");
        step(idle, E_RUN, 0, 0, "md_after");

        // Memory wait released by ready.
        step(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MEM, 0, 0, "mw_enter");
        step(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MEM, 0, 0, "mw_hold");
        step(mk(1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_RUN, 0, 0, "mw_ready");
        step(idle, E_RUN, 0, 0, "mw_after");

        // Memory timeout: 15 frozen cycles, error and release on the 16th.
        for (int k = 0; k < 15; k++) begin
            step(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MEM, 0, 0,
                 $sformatf("to_freeze%0d", k));
        end
        step(mk(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_RUN, 0, 1, "to_release");
        step(idle, E_RUN, 0, 0, "to_after");

        // Reset on the second cycle of MD_BUSY.
        step(mk(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), E_MD, 0, 0, "rmd_enter");
        step(idle, E_MD, 0, 0, "rmd_busy1");
        step(rst_v, E_RST, 0, 0, "rmd_reset");
        step(rst_v, E_RST, 0, 0, "rmd_reset2");
        step(idle, E_RUN, 0, 0, "rmd_run");
        step(idle, E_RUN, 0, 0, "rmd_run2");

        // Single-cycle multiply, short timeout and counter saturation.
        @(negedge clk);
        s_rst = 1'b0;
        s_md  = 1'b1;
        #2;
        chk("sat.md1_done", {15'd0, s_done}, 16'd1);
        chk("sat.md1_ctrl", {8'd0, s_got}, {8'd0, E_RUN});
        @(negedge clk);
        s_md      = 1'b0;
        s_mem_req = 1'b1;
        #2;
        chk("sat.freeze", {8'd0, s_got}, {8'd0, E_MEM});
        chk("sat.count1", {12'd0, s_count}, 16'd0);
        @(negedge clk);
        #2;
        chk("sat.timeout_err", {15'd0, s_err}, 16'd1);
        chk("sat.timeout_ctrl", {8'd0, s_got}, {8'd0, E_RUN});
        // Alternating freeze/release: 20 more freezes push the count past 15.
        for (int k = 0; k < 40; k++) @(negedge clk);
        #2;
        chk("sat.count_sat", {12'd0, s_count}, 16'd15);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("sat.count_hold", {12'd0, s_count}, 16'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
